// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
//
// Multi-channel pushbutton front end for the LED/key user interface.
// Each raw key pin goes through its own two-flop synchroniser and then its
// own debounce state machine. The block produces a clean debounced level
// plus single-cycle press, release and long-press pulses. Downstream control
// logic uses these pulses to step or mode-switch LED patterns.
//
// Parameters
//   INPUT_CLK    : clk frequency in Hz (informational, timing is set below)
//   KEY_NUM      : number of independent key channels (>= 1)
//   COUNT_WIDTH  : width of the per-key counters, holds max(DEBOUNCE_MAX, LONG_MAX)
//   DEBOUNCE_MAX : stability window in clk cycles (>= 1)
//   LONG_MAX     : long-press threshold in cycles after key_press, 0 disables key_long
//   KEY_MODE     : pressed level of the raw pins (0 = active low, 1 = active high)
//
// Ports
//   clk         : system clock, all logic on the rising edge
//   rst         : synchronous active-high reset
//   key         : raw asynchronous bouncing key pins
//   key_state   : debounced level, 1 = pressed
//   key_press   : one-cycle pulse on a debounced press
//   key_release : one-cycle pulse on a debounced release
//   key_long    : one-cycle pulse, at most once per press, after a long hold
// ---------------------------------------------------------------------------
module key_debounce #(
  parameter int INPUT_CLK    = 27_000_000,
  parameter int KEY_NUM      = 4,
  parameter int COUNT_WIDTH  = 26,
  parameter int DEBOUNCE_MAX = 540_000,
  parameter int LONG_MAX     = 27_000_000,
  parameter bit KEY_MODE     = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [KEY_NUM-1:0] key,
  output logic [KEY_NUM-1:0] key_state,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_long
);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] DEB_LIMIT  = COUNT_WIDTH'(DEBOUNCE_MAX);
  localparam logic [COUNT_WIDTH-1:0] LONG_LIMIT = COUNT_WIDTH'(LONG_MAX);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE    = COUNT_WIDTH'(1);
  localparam bit                     LONG_EN    = (LONG_MAX != 0);
  localparam logic                   IDLE_LVL   = ~KEY_MODE;

  // Reject nonsensical configurations at elaboration time so a bad
  // instantiation never silently produces a block that cannot debounce.
  if (INPUT_CLK < 1 || KEY_NUM < 1 || DEBOUNCE_MAX < 1 || LONG_MAX < 0) begin : g_param_check
    $error("key_debounce: invalid parameter set");
  end

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_key
    logic                   sync1;
    logic                   sync2;
    logic                   p;
    state_t                 state;
    logic [COUNT_WIDTH-1:0] dcnt;
    logic [COUNT_WIDTH-1:0] lcnt;
    logic                   long_done;
    logic                   state_q;
    logic                   press_q;
    logic                   release_q;
    logic                   long_q;

    // Two-flop synchroniser for the asynchronous pin. Reset loads the
    // released pin level so that reset never looks like a fresh press
    // edge; a key held through reset is simply re-debounced afterwards.
    always_ff @(posedge clk) begin
      if (rst) begin
        sync1 <= IDLE_LVL;
        sync2 <= IDLE_LVL;
      end else begin
        sync1 <= key[i];
        sync2 <= sync1;
      end
    end

    // Normalise the synchronised sample so that p = 1 always means pressed.
    assign p = sync2 ^ IDLE_LVL;

    // Debounce FSM. A level change must be seen for DEBOUNCE_MAX+1
    // consecutive samples before it is accepted. The long-press counter
    // only advances while the key is solidly pressed; a short release
    // glitch parks it in RELEASE_WAIT without clearing lcnt or long_done,
    // so glitches neither restart nor re-arm the long-press timer.
    // The event pulses default to 0 so each lasts exactly one cycle.
    always_ff @(posedge clk) begin
      if (rst) begin
        state     <= RELEASED;
        dcnt      <= '0;
        lcnt      <= '0;
        long_done <= 1'b0;
        state_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        case (state)
          RELEASED: begin
            if (p) begin
              state <= PRESS_WAIT;
              dcnt  <= CNT_ONE;
            end else begin
              long_done <= 1'b0;
              lcnt      <= '0;
            end
          end
          PRESS_WAIT: begin
            if (!p) begin
              state <= RELEASED;
              dcnt  <= '0;
            end else if (dcnt == DEB_LIMIT) begin
              state   <= PRESSED;
              press_q <= 1'b1;
              state_q <= 1'b1;
              lcnt    <= '0;
            end else begin
              dcnt <= dcnt + CNT_ONE;
            end
          end
          PRESSED: begin
            if (!p) begin
              state <= RELEASE_WAIT;
              dcnt  <= CNT_ONE;
            end else if (LONG_EN && !long_done) begin
              if (lcnt == LONG_LIMIT) begin
                long_q    <= 1'b1;
                long_done <= 1'b1;
              end else begin
                lcnt <= lcnt + CNT_ONE;
              end
            end
          end
          RELEASE_WAIT: begin
            if (p) begin
              state <= PRESSED;
              dcnt  <= '0;
            end else if (dcnt == DEB_LIMIT) begin
              state     <= RELEASED;
              release_q <= 1'b1;
              state_q   <= 1'b0;
            end else begin
              dcnt <= dcnt + CNT_ONE;
            end
          end
          default: begin
            state <= RELEASED;
            dcnt  <= '0;
          end
        endcase
      end
    end

    assign key_state[i]   = state_q;
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;
    assign key_long[i]    = long_q;
  end

endmodule

// File: tb/tb_key_debounce.sv
// ---------------------------------------------------------------------------
// tb_key_debounce
//
// Scoreboard bench for key_debounce with KEY_NUM=4, KEY_MODE=0,
// DEBOUNCE_MAX=4, LONG_MAX=10. Stimulus pushes each expected pulse event
// (cycle number, pulse vectors and resulting key_state) into a queue; an
// independent monitor pops and compares whenever any pulse output is high.
//
// Cycle arithmetic: keys change on a falling edge while cyc = t. The next
// rising edge (cyc = t+1) is E0, so a press or release pulse is expected
// on the edge where cyc = t+1+6 = t+7.
// ---------------------------------------------------------------------------
module tb_key_debounce;

  typedef struct {
    int         cyc;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] lng;
    logic [3:0] state;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] key;
  logic [3:0] key_state;
  logic [3:0] key_press;
  logic [3:0] key_release;
  logic [3:0] key_long;

  int   cyc;
  int   checks;
  int   errors;
  exp_t exp_q[$];
  exp_t mon_e;
  int   t;

  key_debounce #(
    .INPUT_CLK   (27_000_000),
    .KEY_NUM     (4),
    .COUNT_WIDTH (26),
    .DEBOUNCE_MAX(4),
    .LONG_MAX    (10),
    .KEY_MODE    (1'b0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key        (key),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  // Free-running clock and an edge counter used to timestamp events.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop in case something stalls the stimulus process.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, queue depth %0d required 0", exp_q.size());
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic pushExp(input int c, input logic [3:0] pr, input logic [3:0] rl,
                         input logic [3:0] lg, input logic [3:0] st);
    exp_t e;
    e.cyc   = c;
    e.press = pr;
    e.rel   = rl;
    e.lng   = lg;
    e.state = st;
    exp_q.push_back(e);
  endtask

  // Drive a key vector at the current falling edge and hold it for the
  // given number of cycles; returns on a falling edge.
  task automatic applyStimulus(input logic [3:0] k, input int cycles);
    key = k;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %h, required %h", name, cyc, act, req);
    end
  endtask

  // Monitor: any pulse on any channel consumes the next expected event.
  always @(negedge clk) begin
    if ((key_press | key_release | key_long) != 4'b0000) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_event at cycle %0d: press=%b release=%b long=%b, required no event",
                 cyc, key_press, key_release, key_long);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.cyc != cyc || key_press !== mon_e.press || key_release !== mon_e.rel ||
            key_long !== mon_e.lng || key_state !== mon_e.state) begin
          errors++;
          $display("[TB] FAIL event: got cycle %0d press=%b release=%b long=%b state=%b, required cycle %0d press=%b release=%b long=%b state=%b",
                   cyc, key_press, key_release, key_long, key_state,
                   mon_e.cyc, mon_e.press, mon_e.rel, mon_e.lng, mon_e.state);
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    key    = 4'b1111;

    // Reset defaults: everything low, and quiet for 50 cycles.
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checkOutput("reset_idle", {key_state, key_press, key_release, key_long}, 16'h0000);
    end

    // Clean press and release on key 0.
    $display("[TB] clean press on key 0");
    pushExp(cyc + 7, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    applyStimulus(4'b1110, 8);
    pushExp(cyc + 7, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    applyStimulus(4'b1111, 10);
    checkOutput("clean_state_after", {12'h0, key_state}, 16'h0000);

    // Bounce rejection on key 1: pressed runs of 3 and 2 samples are too short.
    $display("[TB] bounce rejection on key 1");
    applyStimulus(4'b1101, 3);
    applyStimulus(4'b1111, 1);
    applyStimulus(4'b1101, 2);
    applyStimulus(4'b1111, 10);
    checkOutput("bounce_state", {12'h0, key_state}, 16'h0000);
    pushExp(cyc + 7, 4'b0010, 4'b0000, 4'b0000, 4'b0010);
    applyStimulus(4'b1101, 8);
    checkOutput("bounce_pressed_state", {12'h0, key_state}, 16'h0002);
    pushExp(cyc + 7, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
    applyStimulus(4'b1111, 10);

    // Long press on key 2 with a 2-cycle release glitch. Press lands at
    // P = t+7. The glitch reaches the FSM on edges P+5 and P+6; the edge
    // that returns to PRESSED (P+7) also does not count, so lcnt sees
    // three stalled edges: key_long at P+11+3 = t+21.
    $display("[TB] long press with glitch on key 2");
    t = cyc;
    pushExp(t + 7, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
    pushExp(t + 21, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
    applyStimulus(4'b1011, 9);
    applyStimulus(4'b1111, 2);
    applyStimulus(4'b1011, 5);
    checkOutput("glitch_state", {12'h0, key_state}, 16'h0004);
    applyStimulus(4'b1011, 24);
    checkOutput("long_held_state", {12'h0, key_state}, 16'h0004);
    pushExp(cyc + 7, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
    applyStimulus(4'b1111, 10);

    // Simultaneous press on keys 0 and 3, then reset while both are held.
    $display("[TB] simultaneous press and mid-press reset");
    pushExp(cyc + 7, 4'b1001, 4'b0000, 4'b0000, 4'b1001);
    applyStimulus(4'b0110, 10);
    checkOutput("simul_state", {12'h0, key_state}, 16'h0009);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("reset_mid", {key_state, key_press, key_release, key_long}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    pushExp(cyc + 7, 4'b1001, 4'b0000, 4'b0000, 4'b1001);
    applyStimulus(4'b0110, 9);
    pushExp(cyc + 7, 4'b0000, 4'b1001, 4'b0000, 4'b0000);
    applyStimulus(4'b1111, 10);

    // Drain any outstanding expectations within a bounded window.
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(negedge clk);
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL missing_event: got no event, required cycle %0d press=%b release=%b long=%b",
               mon_e.cyc, mon_e.press, mon_e.rel, mon_e.lng);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
